// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: shifts an operand one bit per cycle toward MSB (left)
// or LSB (right) until that bit is set, reporting the shift count.
module shift_normalizer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [CW-1:0]    d,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic             mode;
    logic [CW-1:0]    count;
    logic             target;
    logic             unused_op;

    assign unused_op = ^op[3:1];
    assign target    = mode ? work[0] : work[WIDTH-1];
    assign in_ready  = (state == IDLE) && !rst;

    // DONE spends one cycle raising out_valid, then holds until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            res       <= '0;
            d         <= '0;
            zero      <= 1'b0;
            work      <= '0;
            mode      <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= a;
                        mode  <= op[0];
                        count <= '0;
                        if (a == '0) begin
                            res   <= '0;
                            d     <= '0;
                            zero  <= 1'b1;
                            state <= DONE;
                        end else begin
                            zero  <= 1'b0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (target) begin
                        res   <= work;
                        d     <= count;
                        state <= DONE;
                    end else begin
                        work  <= mode ? (work >> 1) : (work << 1);
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed and random checks of shift_normalizer using an expected-result queue.
module tb_shift_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res;
    logic [3:0]  d;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  d;
        logic        zero;
        int          lat;
    } exp_t;

    exp_t sb[$];

    shift_normalizer #(.WIDTH(16), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .d         (d),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic [3:0] dv, input logic z);
        exp_t e;
        e.res  = r;
        e.d    = dv;
        e.zero = z;
        e.lat  = z ? 1 : int'(dv) + 2;
        return e;
    endfunction

    // Reference: locate the highest/lowest set bit directly.
    function automatic exp_t model(input logic [15:0] av, input logic m);
        int p = -1;
        if (av == 16'h0) return mk(16'h0, 4'd0, 1'b1);
        if (!m) begin
            for (int i = 0; i < 16; i++) if (av[i]) p = i;
            return mk(av << (15 - p), 4'(15 - p), 1'b0);
        end
        for (int i = 15; i >= 0; i--) if (av[i]) p = i;
        return mk(av >> p, 4'(p), 1'b0);
    endfunction

    task automatic accept(input logic [15:0] av, input logic [3:0] ov, input exp_t e);
        a        = av;
        op       = ov;
        in_valid = 1'b1;
        chk("in_ready_at_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        a        = 16'($urandom);
        op       = 4'($urandom);
        sb.push_back(e);
    endtask

    task automatic collect(input string tag);
        int   lat = 0;
        exp_t e;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
            chk({tag, "_res"}, 32'(res), 32'(e.res));
            chk({tag, "_d"}, 32'(d), 32'(e.d));
            chk({tag, "_zero"}, 32'(zero), 32'(e.zero));
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic        rm;
        logic        stale;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        op        = 4'h0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Latency extremes and the zero operand
        accept(16'h0001, 4'h0, mk(16'h8000, 4'd15, 1'b0)); collect("clz_lsb");  handshake("clz_lsb");
        accept(16'h8000, 4'h0, mk(16'h8000, 4'd0, 1'b0));  collect("clz_msb");  handshake("clz_msb");
        accept(16'h00F0, 4'h1, mk(16'h000F, 4'd4, 1'b0));  collect("ctz_f0");   handshake("ctz_f0");
        accept(16'h0000, 4'h0, mk(16'h0000, 4'd0, 1'b1));  collect("zero_l");   handshake("zero_l");
        accept(16'h0000, 4'h1, mk(16'h0000, 4'd0, 1'b1));  collect("zero_r");   handshake("zero_r");
        accept(16'h8000, 4'h1, mk(16'h0001, 4'd15, 1'b0)); collect("ctz_msb");  handshake("ctz_msb");
        accept(16'h0100, 4'hF, mk(16'h0001, 4'd8, 1'b0));  collect("op_hi_r");  handshake("op_hi_r");
        accept(16'h0100, 4'hE, mk(16'h8000, 4'd7, 1'b0));  collect("op_hi_l");  handshake("op_hi_l");

        // Backpressure: held result, ignored request until handshake
        accept(16'h0003, 4'h0, mk(16'hC000, 4'd14, 1'b0));
        collect("bp");
        in_valid = 1'b1;
        a        = 16'h1234;
        op       = 4'h0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_res", 32'(res), 32'hC000);
            chk("bp_d", 32'(d), 32'd14);
            chk("bp_zero", 32'(zero), 32'd0);
            tick();
        end
        handshake("bp");
        tick();
        in_valid = 1'b0;
        sb.push_back(mk(16'h91A0, 4'd3, 1'b0));
        collect("bp_next");
        handshake("bp_next");

        // Reset mid-RUN discards the request
        accept(16'h0001, 4'h0, mk(16'h8000, 4'd15, 1'b0));
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        chk("midrun_rst_res", 32'(res), 32'd0);
        sb.delete();
        stale = 1'b0;
        repeat (25) begin
            if (out_valid === 1'b1) stale = 1'b1;
            tick();
        end
        chk("no_stale_result", 32'(stale), 32'd0);
        accept(16'h0400, 4'h0, mk(16'h8000, 4'd5, 1'b0)); collect("post_rst"); handshake("post_rst");

        // Random nonzero operands in both modes
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom_range(1, 65535));
            rm = 1'($urandom);
            accept(ra, {3'($urandom), rm}, model(ra, rm));
            collect("rand");
            if (rm) begin
                chk("rand_inverse_r", 32'(16'(res << d)), 32'(ra));
                chk("rand_lsb_set", 32'(res[0]), 32'd1);
            end else begin
                chk("rand_inverse_l", 32'(16'(res >> d)), 32'(ra));
                chk("rand_msb_set", 32'(res[15]), 32'd1);
            end
            handshake("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
